// File: rtl/rx_receiver_pkg.sv
// rtl/rx_receiver_pkg.sv - shared framing constants, rx state encoding and payload mask helper
package rx_receiver_pkg;

    localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
    localparam logic [7:0]  SFD_PATTERN      = 8'hAB;
    localparam logic [7:0]  CRC_POLY         = 8'h07;

    localparam int LEN_MSB = 3;
    localparam int LEN_LSB = 0;

    localparam int HDR_W = 8;
    localparam int PAY_W = 128;
    localparam int PKT_W = HDR_W + PAY_W;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_CRC    = 2'd3
    } rx_state_e;

    // Keeps the (len+1) received bytes at the top of the payload, zeroes the rest.
    function automatic logic [PAY_W-1:0] payload_mask(input logic [3:0] len);
        logic [8:0] nbits;
        nbits = ({5'd0, len} + 9'd1) << 3;
        return ~({PAY_W{1'b1}} >> nbits);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 (poly 0x07, init 0x00, MSB first)
module crc8_serial
    import rx_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else if (clear) begin
            crc_q <= 8'h00;
        end else if (enable) begin
            crc_q <= {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ data_in}} & CRC_POLY);
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/rx_receiver.sv
// rtl/rx_receiver.sv - serial packet receiver: preamble/SFD hunt, deframing, CRC-8 check; RX_STATS_EN adds packet counters
module rx_receiver
    import rx_receiver_pkg::*;
#(
    parameter int PREAMBLE_MIN = 8,
    parameter int PKT_W        = 136
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_line,
    output logic [PKT_W-1:0] rx_packet,
    output logic             rx_valid,
    output logic             crc_err,
    output logic             rx_busy,
    output logic [15:0]      pkt_ok_cnt,
    output logic [15:0]      pkt_err_cnt
);

    localparam logic [5:0] ALT_MIN = 6'(PREAMBLE_MIN);

    rx_state_e        state_q;
    logic [7:0]       window_q;
    logic             prev_bit_q;
    logic [5:0]       alt_cnt_q;
    logic [7:0]       bit_cnt_q;
    logic [7:0]       hdr_q;
    logic [3:0]       len_q;
    logic [PAY_W-1:0] payload_q;
    logic [7:0]       crc_rx_q;
    logic [PKT_W-1:0] rx_packet_q;
    logic             rx_valid_q;
    logic             crc_err_q;

    logic [7:0] hdr_d;
    logic [7:0] crc_rx_d;
    logic [7:0] crc_calc;
    logic [7:0] data_last;
    logic       sync_hit;

    assign hdr_d     = {hdr_q[6:0], rx_line};
    assign crc_rx_d  = {crc_rx_q[6:0], rx_line};
    assign data_last = {1'b0, len_q, 3'b111};

    // The SFD ends in "11", so the equal-bit test is what separates it from plain preamble.
    assign sync_hit = ({window_q[6:0], rx_line} == SFD_PATTERN) &&
                      rx_line && prev_bit_q && (alt_cnt_q >= ALT_MIN);

    crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_HUNT),
        .enable  (state_q == ST_DATA),
        .data_in (rx_line),
        .crc_out (crc_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            window_q    <= 8'h00;
            prev_bit_q  <= 1'b0;
            alt_cnt_q   <= 6'd0;
            bit_cnt_q   <= 8'd0;
            hdr_q       <= 8'h00;
            len_q       <= 4'd0;
            payload_q   <= '0;
            crc_rx_q    <= 8'h00;
            rx_packet_q <= '0;
            rx_valid_q  <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            prev_bit_q <= rx_line;
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    window_q <= {window_q[6:0], rx_line};
                    if (rx_line != prev_bit_q) begin
                        alt_cnt_q <= (alt_cnt_q == 6'd63) ? alt_cnt_q : alt_cnt_q + 6'd1;
                    end else begin
                        alt_cnt_q <= 6'd0;
                    end
                    if (sync_hit) begin
                        state_q   <= ST_HEADER;
                        bit_cnt_q <= 8'd0;
                    end
                end
                ST_HEADER: begin
                    hdr_q     <= hdr_d;
                    bit_cnt_q <= bit_cnt_q + 8'd1;
                    if (bit_cnt_q == 8'd7) begin
                        len_q     <= hdr_d[LEN_MSB:LEN_LSB];
                        bit_cnt_q <= 8'd0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    payload_q[7'd127 - bit_cnt_q[6:0]] <= rx_line;
                    bit_cnt_q <= bit_cnt_q + 8'd1;
                    if (bit_cnt_q == data_last) begin
                        bit_cnt_q <= 8'd0;
                        state_q   <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    crc_rx_q  <= crc_rx_d;
                    bit_cnt_q <= bit_cnt_q + 8'd1;
                    if (bit_cnt_q == 8'd7) begin
                        rx_valid_q  <= 1'b1;
                        rx_packet_q <= PKT_W'({hdr_q, payload_q & payload_mask(len_q)});
                        crc_err_q   <= (crc_rx_d != crc_calc);
                        state_q     <= ST_HUNT;
                        window_q    <= 8'h00;
                        alt_cnt_q   <= 6'd0;
                        bit_cnt_q   <= 8'd0;
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    assign rx_packet = rx_packet_q;
    assign rx_valid  = rx_valid_q;
    assign crc_err   = crc_err_q;
    assign rx_busy   = (state_q != ST_HUNT);

`ifdef RX_STATS_EN
    logic [15:0] ok_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (rx_valid_q) begin
            if (crc_err_q) begin
                err_cnt_q <= (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            end else begin
                ok_cnt_q <= (ok_cnt_q == 16'hFFFF) ? ok_cnt_q : ok_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;
`else
    assign pkt_ok_cnt  = 16'd0;
    assign pkt_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rx_receiver.sv
// tb/tb_rx_receiver.sv - directed self-checking bench for rx_receiver with a frame-level expectation model
module tb_rx_receiver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_line;
    logic [135:0] rx_packet;
    logic         rx_valid;
    logic         crc_err;
    logic         rx_busy;
    logic [15:0]  pkt_ok_cnt;
    logic [15:0]  pkt_err_cnt;

    rx_receiver #(.PREAMBLE_MIN(8), .PKT_W(136)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_line     (rx_line),
        .rx_packet   (rx_packet),
        .rx_valid    (rx_valid),
        .crc_err     (crc_err),
        .rx_busy     (rx_busy),
        .pkt_ok_cnt  (pkt_ok_cnt),
        .pkt_err_cnt (pkt_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [135:0] pkt;
        logic         err;
        int           due;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   valid_seen = 0;
    int   model_ok = 0;
    int   model_err = 0;

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-at-a-time CRC-8/0x07 over the first nbytes of the payload.
    function automatic logic [7:0] crc8_bytes(input logic [127:0] pay, input int nbytes);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 0; b < nbytes; b++) begin
            c = c ^ pay[127-8*b -: 8];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [127:0] keep_bytes(input logic [127:0] pay, input int nbytes);
        logic [127:0] r;
        r = pay;
        for (int i = 0; i < 128 - 8*nbytes; i++) r[i] = 1'b0;
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_line = 1'b0;
        end
    endtask

    // alt_n < 0: full 0xAAAA preamble + 0xAB; otherwise "11", alt_n alternating bits from 0, then "1".
    // abort_after > 0 stops after that many bits and records no expectation.
    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pay, input bit flip_first,
                              input bit bad_crc, input int abort_after, input int alt_n,
                              output logic [7:0] crc_sent);
        bit           bq[$];
        int           nbytes;
        logic [127:0] orig;
        logic [127:0] sent;
        logic [15:0]  pre;
        logic [7:0]   sfd;
        exp_t         e;
        nbytes = int'(hdr[3:0]) + 1;
        orig = keep_bytes(pay, nbytes);
        sent = orig;
        if (flip_first) sent[127] = ~sent[127];
        crc_sent = crc8_bytes(orig, nbytes) ^ (bad_crc ? 8'h01 : 8'h00);
        pre = 16'hAAAA;
        sfd = 8'hAB;
        if (alt_n < 0) begin
            for (int i = 15; i >= 0; i--) bq.push_back(pre[i]);
            for (int i = 7; i >= 0; i--) bq.push_back(sfd[i]);
        end else begin
            bq.push_back(1'b1);
            bq.push_back(1'b1);
            for (int i = 0; i < alt_n; i++) bq.push_back(i % 2 == 1);
            bq.push_back(1'b1);
        end
        for (int i = 7; i >= 0; i--) bq.push_back(hdr[i]);
        for (int i = 0; i < 8*nbytes; i++) bq.push_back(sent[127-i]);
        for (int i = 7; i >= 0; i--) bq.push_back(crc_sent[i]);
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            rx_line = bq[i];
            if (abort_after > 0 && i + 1 == abort_after) return;
        end
        e.pkt = {hdr, sent};
        e.err = (crc8_bytes(sent, nbytes) != crc_sent);
        e.due = cyc + 1;
        if (e.err) model_err++; else model_ok++;
        expq.push_back(e);
    endtask

    // Cycle-by-cycle compare: rx_valid must pulse exactly on the predicted cycle.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rx_busy) busy_cnt++;
            if (rx_valid) valid_seen++;
            exp_v = (expq.size() > 0) && (expq[0].due == cyc);
            chk("rx_valid", 136'(rx_valid), 136'(exp_v));
            if (exp_v) begin
                e = expq.pop_front();
                chk("rx_packet", rx_packet, e.pkt);
                chk("crc_err", 136'(crc_err), 136'(e.err));
            end
        end
    end

    initial begin
        logic [7:0]   crc_o;
        logic [135:0] p;
        logic [127:0] pay1;
        logic [127:0] pay2;
        int           v0;
        pay1 = {8'h01, 120'h0};
        pay2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst_n = 1'b1;
        rx_line = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_packet", rx_packet, 136'h0);
        chk("reset_valid", 136'(rx_valid), 136'h0);
        chk("reset_err", 136'(crc_err), 136'h0);
        chk("reset_busy", 136'(rx_busy), 136'h0);
        chk("reset_ok_cnt", 136'(pkt_ok_cnt), 136'h0);
        chk("reset_err_cnt", 136'(pkt_err_cnt), 136'h0);
        rst_n = 1'b1;
        idle(4);

        chk("model_crc_01", 136'(crc8_bytes(pay1, 1)), 136'h07);
        chk("model_crc_81", 136'(crc8_bytes({8'h81, 120'h0}, 1)), 136'h8E);

        // 1: minimum length frame
        send_frame(8'hA0, pay1, 1'b0, 1'b0, 0, -1, crc_o);
        chk("t1_crc_sent", 136'(crc_o), 136'h07);
        idle(3);
        chk("t1_packet_held", rx_packet, {8'hA0, 8'h01, 120'h0});

        // 2: maximum length, busy duration
        busy_cnt = 0;
        send_frame(8'h5F, pay2, 1'b0, 1'b0, 0, -1, crc_o);
        idle(3);
        chk("t2_busy_cycles", 136'(busy_cnt), 136'd144);
        chk("t2_packet_held", rx_packet, {8'h5F, pay2});

        // 3: first data bit inverted
        send_frame(8'hA0, pay1, 1'b1, 1'b0, 0, -1, crc_o);
        idle(3);
        p = rx_packet;
        chk("t3_first_byte", 136'(p[127:120]), 136'h81);
        chk("t3_crc_err", 136'(crc_err), 136'h1);

        // 4: short preamble rejected, exactly PREAMBLE_MIN accepted
        busy_cnt = 0;
        v0 = valid_seen;
        send_frame(8'hA0, pay1, 1'b0, 1'b0, 9, 6, crc_o);
        idle(6);
        chk("t4_busy_short", 136'(busy_cnt), 136'd0);
        chk("t4_no_valid", 136'(valid_seen - v0), 136'd0);
        send_frame(8'hA3, pay2, 1'b0, 1'b0, 0, 8, crc_o);
        idle(3);
        send_frame(8'hA0, pay1, 1'b0, 1'b0, 0, -1, crc_o);
        idle(3);
        chk("t4_valid_after", 136'(valid_seen - v0), 136'd2);

        // 5: reset in the middle of DATA
        send_frame(8'h5F, pay2, 1'b0, 1'b0, 35, -1, crc_o);
        @(negedge clk);
        rst_n = 1'b0;
        rx_line = 1'b0;
        #1;
        chk("t5_packet", rx_packet, 136'h0);
        chk("t5_valid", 136'(rx_valid), 136'h0);
        chk("t5_busy", 136'(rx_busy), 136'h0);
        chk("t5_err", 136'(crc_err), 136'h0);
        expq.delete();
        model_ok = 0;
        model_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'hA0, pay1, 1'b0, 1'b0, 0, -1, crc_o);
        idle(3);
        chk("t5_err_after", 136'(crc_err), 136'h0);

        // 6: back-to-back with one idle cycle, second frame bad
        v0 = valid_seen;
        send_frame(8'hA0, pay1, 1'b0, 1'b0, 0, -1, crc_o);
        idle(1);
        send_frame(8'hA0, pay1, 1'b0, 1'b1, 0, -1, crc_o);
        idle(4);
        chk("t6_two_valids", 136'(valid_seen - v0), 136'd2);
        chk("t6_last_err", 136'(crc_err), 136'h1);
`ifdef RX_STATS_EN
        chk("stats_ok", 136'(pkt_ok_cnt), 136'(model_ok));
        chk("stats_err", 136'(pkt_err_cnt), 136'(model_err));
`else
        chk("stats_ok_tied", 136'(pkt_ok_cnt), 136'h0);
        chk("stats_err_tied", 136'(pkt_err_cnt), 136'h0);
`endif
        chk("pending_expectations", 136'(expq.size()), 136'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
